// File: rtl/mult_seq_for_2131.sv
// mult_seq_for_2131: sequential shift-and-add multiplier for the 2131 field.
// Operands are canonicalised into [0, Q-1] with a single conditional
// subtract on accept, then multiplied in exactly W shift/add steps. The
// product is held on o_out_p until the downstream handshake consumes it.
module mult_seq_for_2131 #(
  parameter int Q  = 2131,
  parameter int W  = 12,
  parameter int PW = 23
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [W-1:0]  i_in_a,
  input  logic [W-1:0]  i_in_b,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [PW-1:0] o_out_p,
  output logic [1:0]    o_out_reduced,
  output logic          o_busy
);

  localparam int              CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]    LP_Q    = W'(Q);
  localparam logic [CW-1:0]   LP_LAST = CW'(W - 1);
  localparam logic [CW-1:0]   LP_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One conditional subtract is enough because the largest W-bit input is
  // below 2*Q.
  function automatic logic [W-1:0] canon(input logic [W-1:0] x);
    logic [W-1:0] res;
    if (x >= LP_Q) begin
      res = x - LP_Q;
    end else begin
      res = x;
    end
    return res;
  endfunction

  // Flag telling whether an operand needed the subtract on entry.
  function automatic logic was_reduced(input logic [W-1:0] x);
    return (x >= LP_Q);
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;

  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_a_sh;
  logic [W-1:0]    r_b_sh;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_red;

  logic            r_out_valid;
  logic [PW-1:0]   r_out_p;
  logic [1:0]      r_out_reduced;
  logic            r_busy;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_out_hs;
  logic            w_run_step;
  logic            w_run_last;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_acc_nxt;
  logic [W-1:0]    w_a_canon;
  logic [W-1:0]    w_b_canon;

  // Canonicalised operands and the partial-product adder for one RUN step.
  always_comb begin
    w_a_canon = canon(i_in_a);
    w_b_canon = canon(i_in_b);
    if (r_b_sh[0]) begin
      w_addend = r_a_sh;
    end else begin
      w_addend = {PW{1'b0}};
    end
    w_acc_nxt = r_acc + w_addend;
  end

  // State register: reset discards any operation in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake decode for the current state; in_ready is combinational.
  always_comb begin
    w_in_ready = 1'b0;
    w_out_hs   = 1'b0;
    w_run_step = 1'b0;
    w_run_last = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = !i_rst;
      end
      ST_RUN: begin
        w_run_step = 1'b1;
        w_run_last = (r_cnt == LP_LAST);
      end
      ST_DONE: begin
        w_in_ready = !i_rst && i_out_ready;
        w_out_hs   = r_out_valid && i_out_ready;
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
    w_accept = i_in_valid && w_in_ready;
  end

  // Next-state logic: DONE can go straight back to RUN on a joint handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_run_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (w_out_hs && w_accept) begin
          w_state_nxt = ST_RUN;
        end else if (w_out_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one shift-and-add step per RUN cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= {PW{1'b0}};
      r_a_sh <= {PW{1'b0}};
      r_b_sh <= {W{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_red  <= 2'b00;
    end else if (w_accept) begin
      r_acc  <= {PW{1'b0}};
      r_a_sh <= PW'(w_a_canon);
      r_b_sh <= w_b_canon;
      r_cnt  <= {CW{1'b0}};
      r_red  <= {was_reduced(i_in_b), was_reduced(i_in_a)};
    end else if (w_run_step) begin
      r_acc  <= w_acc_nxt;
      // Bits shifted past PW are never added: b' has only W bits.
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
      r_cnt  <= r_cnt + LP_ONE;
    end else begin
      r_acc  <= r_acc;
      r_a_sh <= r_a_sh;
      r_b_sh <= r_b_sh;
      r_cnt  <= r_cnt;
      r_red  <= r_red;
    end
  end

  // Result registers: loaded on the final step, held until consumed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid   <= 1'b0;
      r_out_p       <= {PW{1'b0}};
      r_out_reduced <= 2'b00;
    end else if (w_run_last) begin
      r_out_valid   <= 1'b1;
      r_out_p       <= w_acc_nxt;
      r_out_reduced <= r_red;
    end else if (w_out_hs) begin
      r_out_valid   <= 1'b0;
      r_out_p       <= r_out_p;
      r_out_reduced <= r_out_reduced;
    end else begin
      r_out_valid   <= r_out_valid;
      r_out_p       <= r_out_p;
      r_out_reduced <= r_out_reduced;
    end
  end

  // Busy flag registered from the next state so it tracks the FSM exactly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_in_ready    = w_in_ready;
  assign o_out_valid   = r_out_valid;
  assign o_out_p       = r_out_p;
  assign o_out_reduced = r_out_reduced;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_mult_seq_for_2131.sv
// Scoreboard bench for mult_seq_for_2131: expected products are queued when
// an accept is seen and compared when the product appears on the output.
module tb_mult_seq_for_2131;

  localparam int Q = 2131;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_p;
  logic [1:0]  out_reduced;
  logic        busy;

  typedef struct {
    int p;
    int red;
    int acc_cyc;
    int gold_mod;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_out = 0;
  int   last_p = -1;
  int   last_red = -1;
  int   prev_rise = 0;
  bit   have_prev = 1'b0;
  bit   stream_mode = 1'b0;
  bit   prev_ov = 1'b0;

  mult_seq_for_2131 dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_a       (in_a),
    .i_in_b       (in_b),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_p      (out_p),
    .o_out_reduced(out_reduced),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int canon_m(input int x);
    return (x >= Q) ? x - Q : x;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      prev_ov = 1'b0;
    end else begin
      check_val("busy", 32'(busy), 32'(q.size() != 0));
      if (out_valid) begin
        if (q.size() == 0) begin
          check_val("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = q[0];
          if (!prev_ov) begin
            n_out++;
            check_val("latency", 32'(cyc - e.acc_cyc), 32'd12);
            if (stream_mode && have_prev) check_val("spacing", 32'(cyc - prev_rise), 32'd13);
            prev_rise = cyc;
            have_prev = 1'b1;
          end
          check_val("out_p", 32'(out_p), 32'(e.p));
          check_val("out_reduced", 32'(out_reduced), 32'(e.red));
          if (out_ready) begin
            if (stream_mode) check_val("gold_mod", 32'(int'(out_p) % Q), 32'(e.gold_mod));
            last_p   = int'(out_p);
            last_red = int'(out_reduced);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        e.p        = canon_m(int'(in_a)) * canon_m(int'(in_b));
        e.red      = ((int'(in_b) >= Q) ? 2 : 0) + ((int'(in_a) >= Q) ? 1 : 0);
        e.acc_cyc  = cyc + 1;
        e.gold_mod = ((int'(in_a) % Q) * (int'(in_b) % Q)) % Q;
        q.push_back(e);
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  // Present a pair and wait for it to be accepted; returns at accept edge + 1.
  task automatic send(input int a, input int b, input bit keep);
    bit got = 1'b0;
    in_a     = 12'(a);
    in_b     = 12'(b);
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    if (!got) check_val("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_val("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val("out_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_out_p"}, 32'(out_p), 32'd0);
    check_val({tag, "_out_reduced"}, 32'(out_reduced), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check_val("in_ready_after_rst", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n_snap;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 12'd1234;
    in_b      = 12'd4000;
    out_ready = 1'b1;

    // Reset state with arbitrary inputs applied
    repeat (2) @(posedge clk);
    #3;
    check_reset_outputs("rst_init");
    release_reset();

    // Max canonical product and canonicalisation cases
    send(2130, 2130, 1'b0);
    wait_drain();
    check_val("max_p", 32'(last_p), 32'd4536900);
    check_val("max_red", 32'(last_red), 32'd0);
    send(4095, 2, 1'b0);
    wait_drain();
    check_val("canon_a_p", 32'(last_p), 32'd3928);
    check_val("canon_a_red", 32'(last_red), 32'd1);
    send(2131, 2131, 1'b0);
    wait_drain();
    check_val("canon_q_p", 32'(last_p), 32'd0);
    check_val("canon_q_red", 32'(last_red), 32'd3);
    send(1234, 1000, 1'b0);
    wait_drain();
    check_val("plain_p", 32'(last_p), 32'd1234000);

    // Backpressure, then joint out-handshake and accept
    out_ready = 1'b0;
    send(1500, 17, 1'b0);
    wait_out_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      check_val("bp_busy", 32'(busy), 32'd1);
      check_val("bp_out_p", 32'(out_p), 32'd25500);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 12'd7;
    in_b      = 12'd9;
    @(negedge clk);
    check_val("bp_joint_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();
    check_val("bp_second_p", 32'(last_p), 32'd63);

    // Asynchronous reset while a product is waiting in DONE
    out_ready = 1'b0;
    send(50, 60, 1'b0);
    wait_out_valid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_done");
    out_ready = 1'b1;
    release_reset();

    // Reset mid-RUN discards the product in flight
    send(100, 200, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    n_snap = n_out;
    repeat (2) @(posedge clk);
    release_reset();
    repeat (20) @(posedge clk);
    #1;
    check_val("no_out_after_rst", 32'(n_out), 32'(n_snap));
    send(3, 5, 1'b0);
    wait_drain();
    check_val("post_rst_p", 32'(last_p), 32'd15);

    // Back-to-back stream of random pairs
    stream_mode = 1'b1;
    have_prev   = 1'b0;
    n_snap      = n_out;
    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1'b1);
    end
    in_valid = 1'b0;
    wait_drain();
    check_val("stream_count", 32'(n_out - n_snap), 32'd20);
    stream_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
